// File: rtl/bp_pkg.sv
// Shared branch-prediction types: 2-bit saturating counter, BTB flush states,
// and the counter update function.
package bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } btb_ctr_t;

  typedef enum logic {
    BTB_IDLE  = 1'b0,
    BTB_CLEAR = 1'b1
  } btb_state_t;

  // Saturating step: never wraps between strongly-taken and strongly-not-taken.
  function automatic btb_ctr_t ctr_next(input btb_ctr_t ctr, input logic taken);
    btb_ctr_t nxt;
    nxt = ctr;
    case (ctr)
      CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
      default: nxt = ctr;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btb_flush_fsm.sv
// Walking invalidate sequencer: clears one BTB entry per cycle while busy,
// restarting from entry 0 whenever flush is re-asserted.
module btb_flush_fsm
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  output logic             o_busy,
  output logic [IDX_W-1:0] o_clr_idx
);

  btb_state_t       r_state;
  btb_state_t       w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx;
  logic [IDX_W-1:0] w_clr_idx_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BTB_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      BTB_IDLE: begin
        if (i_flush) begin
          w_state_nxt   = BTB_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      BTB_CLEAR: begin
        if (i_flush) begin
          w_clr_idx_nxt = '0;
        end else if (r_clr_idx == IDX_W'(ENTRIES - 1)) begin
          w_state_nxt   = BTB_IDLE;
          w_clr_idx_nxt = '0;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = BTB_IDLE;
        w_clr_idx_nxt = '0;
      end
    endcase
  end

  assign o_busy    = (r_state == BTB_CLEAR);
  assign o_clr_idx = r_clr_idx;

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with combinational lookup, resolution-time
// update and a walking flush.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_jump,
  input  logic        flush,
  output logic        busy
);

  localparam int TAG_W = 31 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  btb_ctr_t           r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_clr_idx;
  logic             w_busy;

  btb_flush_fsm #(.ENTRIES(ENTRIES)) u_flush_fsm (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (flush),
    .o_busy    (w_busy),
    .o_clr_idx (w_clr_idx)
  );

  assign busy = w_busy;

  // Halfword-granular indexing; bit 0 of either PC never matters.
  logic             w_unused;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit;

  assign w_unused = &{1'b0, pc[0], upd_pc[0]};
  assign w_idx    = pc[IDX_W:1];
  assign w_tag    = pc[31:IDX_W+1];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  assign pred_hit    = w_hit && !w_busy;
  assign pred_taken  = pred_hit && r_ctr[w_idx][1];
  assign pred_target = pred_taken ? r_target[w_idx] : 32'h0;

  logic [IDX_W-1:0] w_uidx;
  logic [TAG_W-1:0] w_utag;
  logic             w_uhit;
  logic             w_eff_taken;
  logic             w_upd_en;

  assign w_uidx      = upd_pc[IDX_W:1];
  assign w_utag      = upd_pc[31:IDX_W+1];
  assign w_uhit      = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_eff_taken = upd_jump | upd_taken;
  assign w_upd_en    = upd_valid && !w_busy && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_SNT;
      end
    end else begin
      if (w_busy) begin
        r_valid[w_clr_idx] <= 1'b0;
      end
      if (w_upd_en) begin
        if (!w_uhit) begin
          // Only taken control flow earns an entry.
          if (w_eff_taken) begin
            r_valid[w_uidx]  <= 1'b1;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
            r_ctr[w_uidx]    <= upd_jump ? CTR_ST : CTR_WT;
          end
        end else if (upd_jump) begin
          r_target[w_uidx] <= upd_target;
          r_ctr[w_uidx]    <= CTR_ST;
        end else begin
          if (upd_taken) begin
            r_target[w_uidx] <= upd_target;
          end
          r_ctr[w_uidx] <= ctr_next(r_ctr[w_uidx], upd_taken);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES=16).
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic        upd_jump;
  logic        flush;
  logic        busy;

  int total = 0;
  int bad   = 0;

  branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_target  (upd_target),
    .upd_taken   (upd_taken),
    .upd_jump    (upd_jump),
    .flush       (flush),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_update(input logic [31:0] p, input logic [31:0] t,
                           input logic tk, input logic jp);
    upd_valid = 1'b1; upd_pc = p; upd_target = t; upd_taken = tk; upd_jump = jp;
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_jump = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    upd_taken = 1'b0; upd_jump = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++; if (pred_hit !== 1'b0) begin bad++; $display("FAIL reset_hit got=%b want=0", pred_hit); end
    total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b want=0", pred_taken); end
    total++; if (pred_target !== 32'h0) begin bad++; $display("FAIL reset_target got=%h want=0", pred_target); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_counter();
    pc = 32'h100;
    do_update(32'h100, 32'h140, 1'b1, 1'b0);   // alloc ctr=10
    total++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h140}) begin
      bad++; $display("FAIL alloc_taken got=%b%b %h want=11 00000140", pred_hit, pred_taken, pred_target); end
    do_update(32'h100, 32'h999, 1'b0, 1'b0);   // 01, target kept
    total++; if ({pred_hit, pred_taken, pred_target} !== {2'b10, 32'h0}) begin
      bad++; $display("FAIL nt_to_wnt got=%b%b %h want=10 00000000", pred_hit, pred_taken, pred_target); end
    do_update(32'h100, 32'h999, 1'b0, 1'b0);   // 00
    do_update(32'h100, 32'h999, 1'b0, 1'b0);   // hold 00
    total++; if ({pred_hit, pred_taken} !== 2'b10) begin
      bad++; $display("FAIL nt_sat_hit got=%b%b want=10", pred_hit, pred_taken); end
    do_update(32'h100, 32'h180, 1'b1, 1'b0);   // 01 only if held at 00
    total++; if ({pred_hit, pred_taken} !== 2'b10) begin
      bad++; $display("FAIL sat_low got=%b%b want=10", pred_hit, pred_taken); end
    do_update(32'h100, 32'h180, 1'b1, 1'b0);   // 10
    total++; if ({pred_taken, pred_target} !== {1'b1, 32'h180}) begin
      bad++; $display("FAIL retarget got=%b %h want=1 00000180", pred_taken, pred_target); end
  endtask

  task automatic test_jump();
    pc = 32'h200;
    do_update(32'h200, 32'h80, 1'b0, 1'b1);    // ctr=11
    total++; if ({pred_hit, pred_taken, pred_target} !== {2'b11, 32'h80}) begin
      bad++; $display("FAIL jal_alloc got=%b%b %h want=11 00000080", pred_hit, pred_taken, pred_target); end
    do_update(32'h200, 32'h80, 1'b1, 1'b0);    // stays 11
    do_update(32'h200, 32'h80, 1'b0, 1'b0);    // 10, still taken
    total++; if (pred_taken !== 1'b1) begin
      bad++; $display("FAIL sat_high got=%b want=1", pred_taken); end
    pc = 32'h200 + ENTRIES * 2;
    #1;
    total++; if (pred_hit !== 1'b0) begin
      bad++; $display("FAIL alias got=%b want=0", pred_hit); end
  endtask

  task automatic test_miss_not_taken();
    pc = 32'h300;
    do_update(32'h300, 32'h340, 1'b0, 1'b0);
    total++; if (pred_hit !== 1'b0) begin
      bad++; $display("FAIL nt_no_alloc got=%b want=0", pred_hit); end
  endtask

  task automatic test_same_cycle();
    pc = 32'h104;
    upd_valid = 1'b1; upd_pc = 32'h104; upd_target = 32'h1a0; upd_taken = 1'b1; upd_jump = 1'b0;
    #1;
    total++; if (pred_hit !== 1'b0) begin
      bad++; $display("FAIL same_cycle_old got=%b want=0", pred_hit); end
    tick();
    upd_valid = 1'b0; upd_taken = 1'b0;
    #1;
    total++; if ({pred_hit, pred_target} !== {1'b1, 32'h1a0}) begin
      bad++; $display("FAIL same_cycle_new got=%b %h want=1 000001a0", pred_hit, pred_target); end
  endtask

  task automatic populate_all();
    for (int i = 0; i < ENTRIES; i++)
      do_update(32'h400 + 2 * i, 32'h1000 + 4 * i, 1'b0, 1'b1);
  endtask

  task automatic test_flush();
    int n;
    int hits;
    logic forced_ok;
    populate_all();
    pc = 32'h402;
    flush = 1'b1;
    #1;
    total++; if (pred_hit !== 1'b1) begin
      bad++; $display("FAIL flush_cycle_lookup got=%b want=1", pred_hit); end
    tick();
    flush = 1'b0;
    #1;
    n = 0;
    forced_ok = 1'b1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (pred_hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h0) forced_ok = 1'b0;
      if (n == ENTRIES) begin
        upd_valid = 1'b1; upd_pc = 32'h400; upd_target = 32'h5000; upd_jump = 1'b1;
      end
      tick();
      upd_valid = 1'b0; upd_jump = 1'b0;
      #1;
    end
    total++; if (n !== ENTRIES) begin
      bad++; $display("FAIL flush_len got=%0d want=%0d", n, ENTRIES); end
    total++; if (forced_ok !== 1'b1) begin
      bad++; $display("FAIL flush_forced got=%b want=1", forced_ok); end
    hits = 0;
    for (int i = 0; i < ENTRIES; i++) begin
      pc = 32'h400 + 2 * i;
      #1;
      if (pred_hit) hits++;
    end
    total++; if (hits !== 0) begin
      bad++; $display("FAIL flush_empty got=%0d want=0", hits); end
  endtask

  task automatic test_reflush();
    int n;
    do_update(32'h40a, 32'h2000, 1'b0, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (n == 6) flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
    end
    total++; if (n !== 6 + ENTRIES) begin
      bad++; $display("FAIL reflush_len got=%0d want=%0d", n, 6 + ENTRIES); end
  endtask

  task automatic test_rst_midwalk();
    do_update(32'h41e, 32'h3000, 1'b0, 1'b1);  // last index, not reached by walk
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pc = 32'h41e;
    #1;
    total++; if (busy !== 1'b0) begin
      bad++; $display("FAIL rst_walk_busy got=%b want=0", busy); end
    total++; if (pred_hit !== 1'b0) begin
      bad++; $display("FAIL rst_walk_empty got=%b want=0", pred_hit); end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_jump();
    test_miss_not_taken();
    test_same_cycle();
    test_flush();
    test_reflush();
    test_rst_midwalk();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Fetch-side consumer of the decode stage's branch/jump target computation. Caches resolved absolute targets and 2-bit taken history per PC, so fetch can redirect speculatively in the same cycle it presents a PC. Looked up combinationally by fetch and updated at resolution time from decode/execute. Provides a walking invalidate (flush) sequence for fence.i / context change.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, 4..256
IDX_W, $clog2(ENTRIES), index width (derived; not overridden)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
pc  in  32  fetch PC for lookup
pred_hit  out  1  valid entry with matching tag for pc
pred_taken  out  1  predict taken (hit && counter[1] && !busy)
pred_target  out  32  predicted absolute target; 0 when pred_taken=0
upd_valid  in  1  resolution update strobe, one per resolved control-flow instruction
upd_pc  in  32  PC of resolved instruction
upd_target  in  32  resolved absolute target (pc+B/J offset, or rs1+imm for JALR)
upd_taken  in  1  branch resolved taken (ignored when upd_jump=1)
upd_jump  in  1  instruction is JAL/JALR (always taken)
flush  in  1  start invalidate of all entries
busy  out  1  flush walk in progress

Behaviour:
- Indexing: idx = pc[IDX_W:1] (halfword granularity, compressed instructions supported); tag = pc[31:IDX_W+1]. Same split applies to upd_pc.
- Per entry: valid (1), tag (31-IDX_W), target (32), ctr (2-bit saturating: 00 SNT, 01 WNT, 10 WT, 11 ST).
- Lookup is combinational from registered state, zero latency; an update in cycle N becomes visible to lookup in cycle N+1 (lookup in N sees old contents, including the same-index case).
- Update, applied on the clk edge when upd_valid && !busy && !flush:
  - eff_taken = upd_jump | upd_taken.
  - Miss (invalid or tag mismatch) && eff_taken: allocate/replace; tag, target written; ctr = 11 if upd_jump else 10.
  - Miss && !eff_taken: no change (no allocation of not-taken branches).
  - Hit && upd_jump: ctr = 11, target overwritten.
  - Hit && taken: ctr = min(ctr+1, 11), target overwritten.
  - Hit && !taken: ctr = max(ctr-1, 00); target retained; valid retained.
- Flush FSM, states IDLE and CLEAR:
  - IDLE: flush=1 -> CLEAR, clr_idx=0.
  - CLEAR: each cycle valid[clr_idx]=0, clr_idx++. Entry ENTRIES-1 cleared -> IDLE. Walk takes exactly ENTRIES cycles.
  - flush=1 during CLEAR restarts clr_idx at 0.
  - busy=1 in CLEAR. While busy: pred_hit=pred_taken=0, pred_target=0, updates dropped.
  - Cycle flush is asserted in IDLE: update in that cycle dropped; lookup still uses current contents (busy rises next cycle).
- Reset: all valid bits cleared in one cycle; ctr=00, target=0, tag=0; FSM=IDLE, clr_idx=0. Outputs after reset: pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- rst during CLEAR: reset wins; IDLE next cycle, table fully invalid.
- Counter arithmetic is saturating at both ends, with no wrap 11->00 or 00->11.

Decomposition:
- Shared package bp_pkg: typedef btb_ctr_t (2-bit) with enum constants CTR_SNT/WNT/WT/ST; typedef btb_state_t {BTB_IDLE, BTB_CLEAR}; function ctr_next(ctr, taken) for saturating update (reused by any future BHT).
- One natural sub-module: btb_flush_fsm (state, clr_idx, busy). Table storage and lookup stay in the top.

Test Plan:
- Reset then lookup pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0, busy=0.
- Update upd_pc=0x100, target=0x140, taken=1, jump=0; next cycle lookup 0x100 -> hit=1, taken=1, target=0x140. Then two not-taken updates -> ctr 10->01->00, pred_taken=0, pred_hit=1; a further not-taken update holds at 00.
- JAL update pc=0x200, target=0x80, jump=1, taken=0 -> ctr=11; lookup 0x200 -> taken, target 0x80. Aliasing pc=0x200+(ENTRIES*2) -> pred_hit=0.
- Not-taken update on miss pc=0x300 -> no allocation; lookup 0x300 -> pred_hit=0.
- Same-cycle update and lookup on 0x104 -> old value seen that cycle, new value next cycle.
- Populate all ENTRIES; pulse flush -> busy=1 for exactly ENTRIES cycles, preds forced 0, updates during walk dropped; afterwards all lookups miss. Re-flush mid-walk extends the walk; rst mid-walk -> busy=0 next cycle, table empty.
